fdiv_sched: RTL
===============

FDIV_SCHED -- requirements
Module: fdiv_sched

Interface
REQ-001 SHALL have parameter ITERS, default 24, meaning the number of quotient bits, one bit per cycle in ITER.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 has an operand pair.
REQ-005 SHALL have ports req0_a and req0_b, input, 32 each, IEEE-754 single dividend and divisor.
REQ-006 SHALL have port req0_ready, output, 1, requester 0 accepted when valid and ready.
REQ-007 SHALL have ports req1_valid, req1_a, req1_b and req1_ready, identical to REQ-004..006 for requester 1.
REQ-008 SHALL have port res_valid, output, 1, result available.
REQ-009 SHALL have port res_data, output, 32, single-precision quotient.
REQ-010 SHALL have port res_id, output, 1, index of the requester owning res_data.
REQ-011 SHALL have port res_ready, input, 1, consumer takes the result when valid and ready.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ITER, NORM and OUT; the divider is shared and holds at most one operation at a time.
REQ-014 SHALL arbitrate in IDLE only: a single valid requester is granted; if both are valid, grant goes to the requester not granted last (round-robin pointer); req0 wins the first tie after reset.
REQ-015 SHALL drive reqN_ready combinationally high only in IDLE and only for the granted N; both ready outputs are 0 in every other state.
REQ-016 SHALL, on accept, register sign = a[31]^b[31], res_id, the exponents and divider state: remainder = {2'b01, a[22:0]} (25 b) and divisor = {2'b01, b[22:0]} (25 b).
REQ-017 SHALL detect special cases at accept and go straight to OUT, skipping ITER and NORM:
- a or b exponent = 255 -> 32'h7FC00000
- else a exponent = 0 -> {sign, 31'b0}
- else b exponent = 0 -> {sign, 8'hFF, 23'b0}
REQ-018 SHALL, in ITER, perform one restoring step per cycle for ITERS cycles:
- if remainder >= divisor: q = {q, 1} and remainder = (remainder - divisor) << 1
- otherwise: q = {q, 0} and remainder = remainder << 1
- a counter of 0..ITERS-1 ends ITER.
REQ-019 SHALL, in NORM (1 cycle), compute E = ea - eb + 127 in 10-bit signed arithmetic:
- if q[23] = 1: mantissa = q[22:0]
- otherwise: mantissa = {q[21:0], 0} and E = E - 1
- truncate, with no rounding.
REQ-020 SHALL saturate in NORM: E <= 0 -> {sign, 31'b0}; E >= 255 -> {sign, 8'hFF, 23'b0}.
REQ-021 SHALL have a latency of res_valid high 26 cycles after the accept edge for normal operands (ITERS=24) and 1 cycle after it for special cases.
REQ-022 SHALL hold res_valid, res_data and res_id stable in OUT until res_valid and res_ready are both high, then return to IDLE; no accept occurs in that same cycle.
REQ-023 SHALL keep res_valid at 0 outside OUT; res_data keeps its last value.

Reset
REQ-024 SHALL, while rst_n = 0 and regardless of clock, force IDLE, res_valid = 0, res_data = 0, res_id = 0, busy = 0, the counter to 0 and the round-robin pointer to favour req0.
REQ-025 SHALL discard any in-flight operation on reset assertion; no result for it is ever presented.

Verification
REQ-026 SHALL pass: req0 a = 40C00000, b = 40000000 -> res_data = 40400000, res_id = 0, res_valid 26 cycles after accept.
REQ-027 SHALL pass: req1 a = 3F800000, b = 40400000 -> res_data = 3EAAAAAA (truncated, exercises the q[23] = 0 path), res_id = 1.
REQ-028 SHALL pass: req0 and req1 both valid continuously for 3 operations -> grants in order 0, 1, 0; only the granted ready pulses high; every res_id matches its grant.
REQ-029 SHALL pass these special and saturation cases:
- a = 00000000, b = 40000000 -> 00000000 one cycle after accept
- a = C0000000, b = 00000000 -> FF800000
- a = 7F000000, b = 00800000 -> 7F800000
REQ-030 SHALL pass: res_ready held 0 for 10 cycles in OUT -> res_data stable, busy = 1, both ready outputs 0; the result is released on the first res_ready = 1.
REQ-031 SHALL pass: rst_n pulsed low mid-ITER -> res_valid = 0 and busy = 0 immediately; a following req0 40C00000 / 40000000 -> 40400000.

Source files
------------

// File: rtl/fdiv_sched.sv
// Shared single-precision divider for two requesters: round-robin grant in IDLE,
// restoring quotient iteration, normalisation with saturation, then a held result.
module fdiv_sched #(
    parameter int unsigned ITERS = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_id,
    input  logic        res_ready,
    output logic        busy
);
    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int unsigned RW    = 25;
    localparam int unsigned EW    = 10;

    typedef enum logic [1:0] {IDLE, ITER, NORM, OUT} state_t;

    state_t                state, state_nxt;
    logic                  rr_last;
    logic                  sign;
    logic [7:0]            ea, eb;
    logic [RW-1:0]         rem, div;
    logic [ITERS-1:0]      q;
    logic [CNT_W-1:0]      cnt;

    logic                  grant0, grant1, accept;
    logic [31:0]           op_a, op_b;
    logic [7:0]            ea_in, eb_in;
    logic                  sign_in, special;
    logic [31:0]           special_val;
    logic                  rem_ge, last_iter;
    logic [RW-1:0]         rem_next;
    logic [23:0]           qt;
    logic [22:0]           mant;
    logic signed [EW-1:0]  exp_base, exp_norm;
    logic [31:0]           norm_val;

    // rr_last holds the id granted last; a tie goes to the other requester
    assign grant0  = req0_valid && (!req1_valid || rr_last);
    assign grant1  = req1_valid && (!req0_valid || !rr_last);
    assign accept  = (state == IDLE) && (grant0 || grant1);
    assign busy    = (state != IDLE);

    assign op_a    = grant0 ? req0_a : req1_a;
    assign op_b    = grant0 ? req0_b : req1_b;
    assign ea_in   = op_a[30:23];
    assign eb_in   = op_b[30:23];
    assign sign_in = op_a[31] ^ op_b[31];
    assign special = (ea_in == 8'hFF) || (eb_in == 8'hFF) || (ea_in == 8'h00) || (eb_in == 8'h00);
    assign special_val = ((ea_in == 8'hFF) || (eb_in == 8'hFF)) ? 32'h7FC0_0000 :
                         (ea_in == 8'h00) ? {sign_in, 31'b0} : {sign_in, 8'hFF, 23'b0};

    assign rem_ge    = (rem >= div);
    assign rem_next  = (rem_ge ? (rem - div) : rem) << 1;
    assign last_iter = (cnt == CNT_W'(ITERS - 1));

    // Normalisation works on the top 24 quotient bits; truncating, no rounding
    assign qt       = q[ITERS-1 -: 24];
    assign mant     = qt[23] ? qt[22:0] : {qt[21:0], 1'b0};
    assign exp_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    assign exp_norm = qt[23] ? exp_base : exp_base - 10'sd1;
    assign norm_val = (exp_norm <= 10'sd0)   ? {sign, 31'b0} :
                      (exp_norm >= 10'sd255) ? {sign, 8'hFF, 23'b0} :
                                               {sign, exp_norm[7:0], mant};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (accept) state_nxt = special ? OUT : ITER;
            end
            ITER:    if (last_iter) state_nxt = NORM;
            NORM:    state_nxt = OUT;
            OUT:     if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last   <= 1'b1;
            sign      <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            rem       <= '0;
            div       <= '0;
            q         <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rr_last <= grant1;
                    res_id  <= grant1;
                    sign    <= sign_in;
                    ea      <= ea_in;
                    eb      <= eb_in;
                    rem     <= {2'b01, op_a[22:0]};
                    div     <= {2'b01, op_b[22:0]};
                    q       <= '0;
                    cnt     <= '0;
                    if (special) begin
                        res_data  <= special_val;
                        res_valid <= 1'b1;
                    end
                end
                ITER: begin
                    q   <= {q[ITERS-2:0], rem_ge};
                    rem <= rem_next;
                    cnt <= last_iter ? '0 : cnt + CNT_W'(1);
                end
                NORM: begin
                    res_data  <= norm_val;
                    res_valid <= 1'b1;
                end
                OUT: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
